// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX front end: RX_IN synchroniser, oversampling edge/bit counters and bit sampler.
// Build option: define UART_RX_MAJORITY_VOTE_EN for the three-point majority vote.
module uart_rx_edge_bit_sampler #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 11
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] Prescale,
  input  logic       cnt_en,
  input  logic       dat_samp_en,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       sampled_bit,
  output logic       samp_vld
);

  localparam int unsigned EW = 6;
  localparam int unsigned BW = 4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [EW-1:0]          p_q;
  logic [EW-1:0]          mid;
  logic [EW-1:0]          edge_last;
  logic                   rx_s;
  logic                   samp_en;
  logic                   at_mid;
  logic                   prescale_ok;
  logic                   vote;

  assign rx_s        = sync_q[SYNC_STAGES-1];
  assign mid         = p_q >> 1;
  assign edge_last   = p_q - EW'(1);
  assign samp_en     = cnt_en & dat_samp_en;
  assign at_mid      = (edge_cnt == mid);
  assign prescale_ok = (Prescale == EW'(8)) || (Prescale == EW'(16)) || (Prescale == EW'(32));

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic s0;
  logic s1;

  // Early/late sample points ahead of the mid-bit vote
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else if (samp_en) begin
      if (edge_cnt == mid - EW'(2)) s0 <= rx_s;
      if (edge_cnt == mid - EW'(1)) s1 <= rx_s;
    end
  end

  assign vote = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
`else
  assign vote = rx_s;
`endif

  // Synchroniser, prescale latch, counters and sampled bit
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q      <= '1;
      p_q         <= EW'(8);
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      sampled_bit <= 1'b1;
      samp_vld    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], RX_IN};
      samp_vld <= 1'b0;
      if (!cnt_en) begin
        // Prescale only moves while idle; illegal ratios fall back to 8
        p_q      <= prescale_ok ? Prescale : EW'(8);
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if (edge_cnt == edge_last) begin
          edge_cnt <= '0;
          bit_cnt  <= (bit_cnt == BW'(FRAME_BITS - 1)) ? '0 : bit_cnt + BW'(1);
        end else begin
          edge_cnt <= edge_cnt + EW'(1);
        end
        if (samp_en && at_mid) begin
          sampled_bit <= vote;
          samp_vld    <= 1'b1;
        end
      end
    end
  end

endmodule
